dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-ported, byte-addressed data memory. The core load/store unit (port 0) and a DMA/debug master (port 1) share the memory. The arbiter grants one access per cycle and drives the memory control bus. It tracks the memory's one-cycle synchronous read latency so each read result returns to the requester that issued it. Misaligned, illegal-size and out-of-range accesses are rejected with an error response and never reach the memory.

## Interface
Parameters:
- ADDR_BITS, 12, byte-address width backed by memory (1024 words); any set bit above ADDR_BITS-1 is out of range.

Ports (p = 0,1; per-port signals are 2-element arrays indexed by p):
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid[p]  in  1  request present.
- req_ready[p]  out  1  request accepted this cycle when valid&&ready.
- req_write[p]  in  1  1 = store, 0 = load.
- req_size[p]  in  3  transfer size in bytes: 1, 2 or 4.
- req_unsigned[p]  in  1  zero-extend loads (1) or sign-extend (0).
- req_addr[p]  in  32  byte address.
- req_wdata[p]  in  32  store data, LSB-aligned.
- resp_valid[p]  out  1  response strobe, one cycle, no backpressure.
- resp_err[p]  out  1  with resp_valid: access rejected.
- resp_data[p]  out  32  load data; 0 for stores and errors.
- mem_write, mem_read, is_unsigned  out  1  memory controls.
- xfer_size  out  3  memory transfer size.
- address, w_data  out  32  memory address and store data.
- r_data  in  32  memory read data, valid one cycle after the read is issued.

## Operation
- Arbitration is per cycle and has no state machine beyond the grant pointer. At most one of req_ready[0..1] is high, and only when that port's req_valid is high.
- Fixed priority (macro off): port 0 always wins.
- Legality check on the granted request, classified as error if any of these hold:
  - size not in {1,2,4};
  - size 2 with addr[0]=1;
  - size 4 with addr[1:0]≠0;
  - addr[31:ADDR_BITS]≠0.
- Legal grant: mem_read=~req_write, mem_write=req_write, and xfer_size, is_unsigned, address, w_data pass through combinationally from the granted port.
- Error grant, or no grant: mem_read=mem_write=0, and all other memory outputs are 0.
- Response pipeline, one registered stage: {valid, port, err, was_read}. The response is produced in the cycle after acceptance, on the owning port only:
  - loads: resp_data=r_data;
  - stores: resp_data=0;
  - errors: resp_err=1, resp_data=0.
- Throughput is one accepted request per cycle. Back-to-back accesses from alternating ports are allowed.

## Timing
- Accept in cycle N. Memory samples its controls at the end of N. resp_valid, resp_err and resp_data are valid in N+1, so read latency is 1 cycle.
- A store accepted in N is visible to a load accepted in N+1 (read-after-write through memory ordering).
- Reset values:
  - resp_valid=0, resp_err=0, resp_data=0;
  - req_ready=0 while rst_n is low;
  - memory controls 0;
  - grant pointer = port 0.
- Reset asserted mid-operation: the pending response is dropped and no resp_valid follows. A store issued in the same cycle as reset assertion is not guaranteed.
- Simultaneous valid requests: the loser holds its request stable until ready; ready never depends on resp signals.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. A 1-bit last-grant register flips to the granted port on each accept, and on contention the port not granted last wins. The register resets to 1 so port 0 wins the first contention.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 over port 1, with no last-grant register.

## Structure
- Package dmem_pkg:
  - constants SIZE_B=3'd1, SIZE_H=3'd2, SIZE_W=3'd4;
  - typedef port_idx_t (1 bit);
  - packed struct dmem_req_t {write, size, unsigned, addr, wdata};
  - packed struct resp_pipe_t.
- Sub-module dmem_align_check: combinational legality check (size, addr → err), instantiated once on the granted request.

## Test plan
- Port 0 store word 0xDF0D873C to 0x10, then load word 0x10 → resp_valid[0] in each following cycle, load resp_data=0xDF0D873C, err=0.
- Port 1 load byte signed at 0x13 after the above store → resp_data=0xFFFFFFDF. Unsigned halfword at 0x12 → 0x0000DF0D.
- Both ports valid for 4 cycles with macro off → port 0 granted every cycle. With DMEM_ARB_RR_EN → grants alternate 0,1,0,1.
- Port 0 word load at 0x2, halfword at 0x1, size 3 at 0x0, and word at 0x1000 → each gives resp_err=1, data 0, with mem_read/mem_write low in the accept cycle.
- Port 1 load accepted, rst_n pulsed low before the next posedge → no resp_valid after reset, all outputs 0, and the next accept behaves normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
//   SIZE_B/H/W  : legal transfer sizes in bytes
//   port_idx_t  : requester index (0 = load/store unit, 1 = DMA/debug)
//   dmem_req_t  : one requester's access as seen after the grant mux
//   resp_pipe_t : the single registered response stage
package dmem_pkg;

   localparam logic [2:0] SIZE_B = 3'd1;
   localparam logic [2:0] SIZE_H = 3'd2;
   localparam logic [2:0] SIZE_W = 3'd4;

   typedef logic port_idx_t;

   typedef struct packed {
      logic        write;
      logic [2:0]  size;
      logic        unsgn;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   typedef struct packed {
      logic      vld;
      port_idx_t port;
      logic      err;
      logic      was_read;
   } resp_pipe_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and memory-side bus of the data-memory arbiter.
//   Per-port request/response signals are packed [1:0] arrays indexed by port.
//   slave  : the arbiter (consumes requests and r_data, drives everything else)
//   master : requesters plus the memory (drive requests and r_data)
interface dmem_arbiter_if;

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_write;
   logic [1:0][2:0]  req_size;
   logic [1:0]       req_unsigned;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_err;
   logic [1:0][31:0] resp_data;

   logic             mem_write;
   logic             mem_read;
   logic             is_unsigned;
   logic [2:0]       xfer_size;
   logic [31:0]      address;
   logic [31:0]      w_data;
   logic [31:0]      r_data;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, r_data,
      output req_ready, resp_valid, resp_err, resp_data,
             mem_write, mem_read, is_unsigned, xfer_size, address, w_data
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, r_data,
      input  req_ready, resp_valid, resp_err, resp_data,
             mem_write, mem_read, is_unsigned, xfer_size, address, w_data
   );

endinterface

// File: rtl/dmem_arbiter_align_check.sv
// dmem_align_check: combinational legality check of one access.
//   size_i : transfer size in bytes
//   addr_i : byte address
//   err_o  : 1 when the size is illegal, the address is misaligned for the
//            size, or any address bit at or above ADDR_BITS is set
module dmem_align_check
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS = 12
) (
   input  logic [2:0]  size_i,
   input  logic [31:0] addr_i,
   output logic        err_o
);

   always_comb begin
      err_o = 1'b1;
      case (size_i)
         SIZE_B:  err_o = 1'b0;
         SIZE_H:  err_o = addr_i[0];
         SIZE_W:  err_o = |addr_i[1:0];
         default: err_o = 1'b1;
      endcase
      if (|addr_i[31:ADDR_BITS]) err_o = 1'b1;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the single-ported data memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave -- requests/responses for ports 0 and 1
//                plus the memory control bus (combinational from the grant)
// One request is accepted per cycle. Illegal accesses are answered with
// resp_err and never reach the memory. The response for an access accepted in
// cycle N appears in N+1 on the owning port, with r_data forwarded for loads.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration; otherwise
// port 0 has fixed priority.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS = 12
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);

   port_idx_t  gnt;
   logic       accept;
   logic       err;
   logic       legal;
   dmem_req_t  req;
   resp_pipe_t pipe_d, pipe_q;

`ifdef DMEM_ARB_RR_EN
   // Last-grant register; resets to 1 so port 0 wins the first contention.
   port_idx_t last_q;

   assign gnt = (&bus.req_valid) ? ~last_q : bus.req_valid[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_q <= 1'b1;
      else if (accept) last_q <= gnt;
   end
`else
   assign gnt = ~bus.req_valid[0];
`endif

   // Ready is gated by rst_n so nothing is accepted while reset is held.
   assign accept = rst_n && bus.req_valid[gnt];

   always_comb begin
      bus.req_ready      = '0;
      bus.req_ready[gnt] = accept;
   end

   assign req = '{write: bus.req_write[gnt],
                  size:  bus.req_size[gnt],
                  unsgn: bus.req_unsigned[gnt],
                  addr:  bus.req_addr[gnt],
                  wdata: bus.req_wdata[gnt]};

   dmem_align_check #(.ADDR_BITS(ADDR_BITS)) u_chk (
      .size_i (req.size),
      .addr_i (req.addr),
      .err_o  (err)
   );

   assign legal = accept && !err;

   always_comb begin
      bus.mem_read    = legal && !req.write;
      bus.mem_write   = legal &&  req.write;
      bus.is_unsigned = legal ? req.unsgn : 1'b0;
      bus.xfer_size   = legal ? req.size  : 3'd0;
      bus.address     = legal ? req.addr  : 32'd0;
      bus.w_data      = legal ? req.wdata : 32'd0;
   end

   always_comb begin
      pipe_d = '0;
      if (accept) pipe_d = '{vld: 1'b1, port: gnt, err: err, was_read: legal && !req.write};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= pipe_d;
   end

   always_comb begin
      bus.resp_valid = '0;
      bus.resp_err   = '0;
      bus.resp_data  = '0;
      for (int p = 0; p < 2; p++) begin
         if (pipe_q.vld && (pipe_q.port == port_idx_t'(p))) begin
            bus.resp_valid[p] = 1'b1;
            bus.resp_err[p]   = pipe_q.err;
            bus.resp_data[p]  = pipe_q.was_read ? bus.r_data : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a byte-addressed
// little-endian memory model (1-cycle read latency, extension done by memory).
module tb_dmem_arbiter;
   import dmem_pkg::*;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [7:0] mem [0:4095];

   dmem_arbiter_if ifc ();

   dmem_arbiter #(.ADDR_BITS(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // Memory model: stores land at the posedge; loads return extended data
   // registered at the posedge, i.e. one cycle after the read was issued.
   function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] sz, input logic u);
      logic [31:0] raw;
      raw = {mem[(a + 3) & 32'hFFF], mem[(a + 2) & 32'hFFF], mem[(a + 1) & 32'hFFF], mem[a & 32'hFFF]};
      case (sz)
         3'd1:    return u ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         3'd2:    return u ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   always @(posedge clk) begin
      if (ifc.mem_write)
         for (int i = 0; i < 4; i++)
            if (i < int'(ifc.xfer_size)) mem[(ifc.address + i) & 32'hFFF] <= ifc.w_data[8*i +: 8];
      if (ifc.mem_read) ifc.r_data <= mem_rd(ifc.address, ifc.xfer_size, ifc.is_unsigned);
   end

   // Monitor: every response strobe pops the owning port's queue.
   always @(negedge clk) begin
      exp_t e;
      for (int p = 0; p < 2; p++) begin
         if (ifc.resp_valid[p]) begin
            if ((p == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
               chk(p == 0 ? "unexpected_resp_p0" : "unexpected_resp_p1", 64'd1, 64'd0);
            end else begin
               e = (p == 0) ? q0.pop_front() : q1.pop_front();
               chk(p == 0 ? "resp_p0" : "resp_p1",
                   {31'd0, ifc.resp_err[p], ifc.resp_data[p]}, {31'd0, e.err, e.data});
            end
         end
      end
   end

   task automatic push(input int p, input logic err, input logic [31:0] d);
      if (p == 0) q0.push_back('{err: err, data: d});
      else        q1.push_back('{err: err, data: d});
   endtask

   task automatic drive(input int p, input logic wr, input logic [2:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
      ifc.req_valid[p]    = 1'b1;
      ifc.req_write[p]    = wr;
      ifc.req_size[p]     = sz;
      ifc.req_unsigned[p] = u;
      ifc.req_addr[p]     = a;
      ifc.req_wdata[p]    = wd;
   endtask

   // Presents one request, waits (bounded) for ready, checks the memory bus in
   // the accept cycle and records the expected response.
   task automatic issue(input int p, input logic wr, input logic [2:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic xerr, input logic [31:0] xdata);
      int n = 0;
      drive(p, wr, sz, u, a, wd);
      @(negedge clk);
      while (!ifc.req_ready[p] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.req_ready[p]) begin
         chk("ready_timeout", 64'd0, 64'd1);
      end else begin
         if (xerr)
            chk("err_membus", {ifc.mem_read, ifc.mem_write, ifc.address}, 64'd0);
         else
            chk("membus", {ifc.mem_read, ifc.mem_write, ifc.xfer_size, ifc.is_unsigned, ifc.address},
                {~wr, wr, sz, u, a});
         push(p, xerr, xdata);
      end
      @(posedge clk);
      #1;
      ifc.req_valid[p] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      ifc.req_valid = 2'b11;
      ifc.req_write = '0;
      ifc.req_size = '{default: 3'd4};
      ifc.req_unsigned = '0;
      ifc.req_addr = '0;
      ifc.req_wdata = '0;
      ifc.r_data = '0;

      // Reset state with both requests present.
      repeat (2) @(negedge clk);
      chk("rst_ready_resp", {ifc.req_ready, ifc.resp_valid, ifc.resp_err}, 64'd0);
      chk("rst_resp_data", ifc.resp_data, 64'd0);
      chk("rst_memctl", {ifc.mem_read, ifc.mem_write, ifc.is_unsigned, ifc.xfer_size, ifc.address}, 64'd0);
      @(posedge clk);
      #1;
      ifc.req_valid = 2'b00;
      rst_n = 1'b1;

      // Store then back-to-back load; then port 1 byte/halfword loads.
      issue(0, 1'b1, SIZE_W, 1'b0, 32'h10, 32'hDF0D873C, 1'b0, 32'h0);
      issue(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDF0D873C);
      issue(1, 1'b0, SIZE_B, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDF);
      issue(1, 1'b0, SIZE_H, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000DF0D);

      // Contention for 4 cycles.
      drive(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0);
      drive(1, 1'b0, SIZE_H, 1'b1, 32'h10, 32'h0);
      for (int i = 0; i < 4; i++) begin
         int g;
`ifdef DMEM_ARB_RR_EN
         g = i % 2;
`else
         g = 0;
`endif
         @(negedge clk);
         chk("contend_grant", {62'd0, ifc.req_ready}, 64'd1 << g);
         if (g == 0) push(0, 1'b0, 32'hDF0D873C);
         else        push(1, 1'b0, 32'h0000873C);
         @(posedge clk);
         #1;
      end
      ifc.req_valid[0] = 1'b0;
      @(negedge clk);
      chk("loser_grant", {62'd0, ifc.req_ready}, 64'd2);
      push(1, 1'b0, 32'h0000873C);
      @(posedge clk);
      #1;
      ifc.req_valid[1] = 1'b0;

      // Top of the address range.
      issue(1, 1'b1, SIZE_B, 1'b0, 32'hFFF, 32'h000000A5, 1'b0, 32'h0);
      issue(0, 1'b0, SIZE_B, 1'b1, 32'hFFF, 32'h0, 1'b0, 32'h000000A5);

      // Rejected accesses.
      issue(0, 1'b0, SIZE_W, 1'b0, 32'h2,    32'h0, 1'b1, 32'h0);
      issue(0, 1'b0, SIZE_H, 1'b0, 32'h1,    32'h0, 1'b1, 32'h0);
      issue(0, 1'b0, 3'd3,   1'b0, 32'h0,    32'h0, 1'b1, 32'h0);
      issue(0, 1'b0, SIZE_W, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
      issue(0, 1'b1, SIZE_W, 1'b0, 32'h1000, 32'h12345678, 1'b1, 32'h0);

      // Accept a port 1 load, then reset before its response is seen.
      drive(1, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("pre_rst_ready", {62'd0, ifc.req_ready}, 64'd2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready_resp", {ifc.req_ready, ifc.resp_valid, ifc.resp_err}, 64'd0);
      chk("midrst_resp_data", ifc.resp_data, 64'd0);
      chk("midrst_memctl", {ifc.mem_read, ifc.mem_write, ifc.address}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(1, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDF0D873C);

      repeat (3) @(negedge clk);
      chk("drained", {32'(q0.size()), 32'(q1.size())}, 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
